// File: rtl/register_file_pkg.sv
// Shared widths, identifiers and opcode constants for the register file, ROB and decoder.
// ROB id 0 (NO_DEP) is reserved to mean "value is architecturally current".
package register_file_pkg;

    localparam int ROB_ID_W = 5;
    localparam int REG_ID_W = 5;
    localparam int NUM_REGS = 32;
    localparam int XLEN     = 32;

    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [XLEN-1:0]     xlen_t;

    localparam rob_id_t NO_DEP = 5'd0;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    // x0 is hardwired to zero and never takes a value or a tag.
    function automatic logic is_writable(input reg_id_t r);
        return r != '0;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// ROB/decoder-facing bus of the register file: launch, commit, flush and two source queries.
// The master is the ROB/decoder side; the slave is the register file itself.
interface register_file_if;
    import register_file_pkg::*;

    logic    _clear;
    logic    _rf_launch_ready;
    rob_id_t _rf_launch_rob_id;
    reg_id_t _rf_launch_register_id;
    logic    _rf_commit_ready;
    rob_id_t _rf_commit_rob_id;
    reg_id_t _rf_commit_register_id;
    xlen_t   _rf_commit_value;
    reg_id_t _ask_rd_1;
    reg_id_t _ask_rd_2;
    rob_id_t _dep_rd_1;
    rob_id_t _dep_rd_2;
    xlen_t   _dep_value_1;
    xlen_t   _dep_value_2;

    modport master (
        output _clear,
        output _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
        output _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id, _rf_commit_value,
        output _ask_rd_1, _ask_rd_2,
        input  _dep_rd_1, _dep_rd_2, _dep_value_1, _dep_value_2
    );

    modport slave (
        input  _clear,
        input  _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
        input  _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id, _rf_commit_value,
        input  _ask_rd_1, _ask_rd_2,
        output _dep_rd_1, _dep_rd_2, _dep_value_1, _dep_value_2
    );

endinterface

// File: rtl/register_file_rf_read_port.sv
// One combinational source-operand query with commit bypass.
// Launch inputs are deliberately absent: a dispatching instruction must not see its own tag.
module rf_read_port
    import register_file_pkg::*;
(
    input  reg_id_t ask_i,
    input  logic    commit_ready_i,
    input  rob_id_t commit_rob_id_i,
    input  reg_id_t commit_register_id_i,
    input  xlen_t   commit_value_i,
    input  rob_id_t tag_q_i   [NUM_REGS],
    input  xlen_t   value_q_i [NUM_REGS],
    output rob_id_t dep_o,
    output xlen_t   value_o
);

    logic bypass_hit;

    // Only the commit of the producer we are still waiting on may forward its result.
    assign bypass_hit = commit_ready_i
                     && (commit_register_id_i == ask_i)
                     && (tag_q_i[ask_i] == commit_rob_id_i);

    always_comb begin
        dep_o   = NO_DEP;
        value_o = '0;
        if (is_writable(ask_i)) begin
            if (bypass_hit) begin
                value_o = commit_value_i;
            end else begin
                dep_o   = tag_q_i[ask_i];
                value_o = value_q_i[ask_i];
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags; responder on the ROB bus.
// Commit is applied before launch so a same-cycle launch to the same register keeps its tag.
module register_file
    import register_file_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    register_file_if.slave rf
);

    xlen_t   value_q [NUM_REGS];
    xlen_t   value_d [NUM_REGS];
    rob_id_t tag_q   [NUM_REGS];
    rob_id_t tag_d   [NUM_REGS];

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        if (rdy_in) begin
            if (rf._rf_commit_ready && is_writable(rf._rf_commit_register_id)) begin
                value_d[rf._rf_commit_register_id] = rf._rf_commit_value;
                if (tag_q[rf._rf_commit_register_id] == rf._rf_commit_rob_id) begin
                    tag_d[rf._rf_commit_register_id] = NO_DEP;
                end
            end
            // A flush drops every tag, including the one a same-cycle launch would set.
            if (rf._clear) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    tag_d[i] = NO_DEP;
                end
            end else if (rf._rf_launch_ready && is_writable(rf._rf_launch_register_id)) begin
                tag_d[rf._rf_launch_register_id] = rf._rf_launch_rob_id;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= NO_DEP;
            end
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    rf_read_port u_read_port_1 (
        .ask_i                (rf._ask_rd_1),
        .commit_ready_i       (rf._rf_commit_ready),
        .commit_rob_id_i      (rf._rf_commit_rob_id),
        .commit_register_id_i (rf._rf_commit_register_id),
        .commit_value_i       (rf._rf_commit_value),
        .tag_q_i              (tag_q),
        .value_q_i            (value_q),
        .dep_o                (rf._dep_rd_1),
        .value_o              (rf._dep_value_1)
    );

    rf_read_port u_read_port_2 (
        .ask_i                (rf._ask_rd_2),
        .commit_ready_i       (rf._rf_commit_ready),
        .commit_rob_id_i      (rf._rf_commit_rob_id),
        .commit_register_id_i (rf._rf_commit_register_id),
        .commit_value_i       (rf._rf_commit_value),
        .tag_q_i              (tag_q),
        .value_q_i            (value_q),
        .dep_o                (rf._dep_rd_2),
        .value_o              (rf._dep_value_2)
    );

endmodule
